reg_snap_fifo: RTL

AXI4-Lite slave that captures wide PL data snapshots (N_WORDS x 32b) on a one-cycle capture pulse. Unlike a single-snapshot register bank, it queues up to DEPTH snapshots, so the PS can drain bursts without losing packets. It counts dropped captures, exposes FIFO status, and raises an optional level interrupt. It sits between the packet assembler in the PL and the PS Wi-Fi send task.

---
 rtl/reg_snap_fifo.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_snap_fifo.sv
// AXI4-Lite slave queuing up to DEPTH wide PL snapshots for the PS to drain.
// Tracks dropped captures, exposes FIFO status and raises a level interrupt.
module reg_snap_fifo #(
  parameter int N_WORDS              = 56,
  parameter int DEPTH                = 4,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 9
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,

  input  logic [N_WORDS*32-1:0]               data_i,
  input  logic                                capture_i,
  input  logic                                ready_i,
  output logic                                clr_o,
  output logic                                irq_o,

  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready
);

  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] ADDR_STATUS = AW'(32'h1E0);
  localparam logic [AW-1:0] ADDR_DROP   = AW'(32'h1E4);
  localparam logic [AW-1:0] ADDR_CTRL   = AW'(32'h1E8);

  logic [N_WORDS*32-1:0] slot_mem [DEPTH];
  logic [N_WORDS*32-1:0] head;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic          irq_en;

  logic [AW-3:0] wr_idx;
  logic [AW-3:0] rd_idx;
  logic          wr_hs;
  logic          rd_hs;
  logic          ctrl_wr;
  logic          drop_wr;
  logic          pop_req;
  logic          flush_req;
  logic          clr_req;
  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          cap_ok;
  logic          cap_drop;
  logic [31:0]   status_word;
  logic [31:0]   rd_word;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wdata[C_S00_AXI_DATA_WIDTH-1:4],
                         s00_axi_wstrb[C_S00_AXI_DATA_WIDTH/8-1:1]};

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;

  // Write decode
  assign wr_idx  = s00_axi_awaddr[AW-1:2];
  assign rd_idx  = s00_axi_araddr[AW-1:2];
  assign wr_hs   = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;
  assign rd_hs   = s00_axi_arready & s00_axi_arvalid;
  assign ctrl_wr = wr_hs & (wr_idx == ADDR_CTRL[AW-1:2]) & s00_axi_wstrb[0];
  assign drop_wr = wr_hs & (wr_idx == ADDR_DROP[AW-1:2]);

  assign pop_req   = ctrl_wr & s00_axi_wdata[0];
  assign flush_req = ctrl_wr & s00_axi_wdata[1];
  assign clr_req   = ctrl_wr & s00_axi_wdata[2];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the slot a same-cycle capture needs when full; flush wins over both.
  assign pop_ok   = pop_req & ~empty & ~flush_req;
  assign cap_ok   = capture_i & ~flush_req & (~full | pop_ok);
  assign cap_drop = capture_i & ~flush_req & full & ~pop_ok;

  always_ff @(posedge s00_axi_aclk) begin
    if (cap_ok) begin
      slot_mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (cap_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(cap_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      drop_cnt <= '0;
      irq_en   <= 1'b0;
      irq_o    <= 1'b0;
      clr_o    <= 1'b0;
    end else begin
      if (drop_wr) begin
        drop_cnt <= '0;
      end else if (cap_drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (ctrl_wr) begin
        irq_en <= s00_axi_wdata[3];
      end
      irq_o <= irq_en & ~empty;
      clr_o <= clr_req;
    end
  end

  // Read path: head slot words, then status registers
  assign head        = slot_mem[rd_ptr];
  assign status_word = {15'b0, irq_en, 3'b0, 5'(count), 5'b0, full, ~empty, ready_i};

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (rd_idx == (AW-2)'(k)) begin
        rd_word = head[k*32 +: 32];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_idx == ADDR_STATUS[AW-1:2]) begin
      rd_mux = status_word;
    end else if (rd_idx == ADDR_DROP[AW-1:2]) begin
      rd_mux = {16'b0, drop_cnt};
    end else if (!empty) begin
      rd_mux = rd_word;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
      s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
      if (wr_hs) begin
        s00_axi_bvalid <= 1'b1;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end

      s00_axi_arready <= s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_arready;
      if (rd_hs) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
